// File: rtl/uart_tx_fifo_pkg.sv
// rtl/uart_tx_fifo_pkg.sv - shared defaults and pacing FSM state type for uart_tx_fifo
package uart_tx_fifo_pkg;

  localparam int DATA_BITS_DEF     = 8;
  localparam int FIFO_DEPTH_DEF    = 16;
  localparam int WAIT_BUSY_TIMEOUT = 2;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - producer write port, uart_tx pacing and status signals
interface uart_tx_fifo_if #(
  parameter int data_bits  = 8,
  parameter int fifo_depth = 16
) ();

  logic                          wr_en;
  logic [data_bits-1:0]          wr_data;
  logic                          wr_ready;
  logic                          flush;
  logic                          ovf_clr;
  logic                          tx_data_vld;
  logic [data_bits-1:0]          tx_data_out;
  logic                          tx_active;
  logic [$clog2(fifo_depth):0]   fifo_count;
  logic                          fifo_empty;
  logic                          overflow;

  modport master (
    output wr_en, wr_data, flush, ovf_clr, tx_active,
    input  wr_ready, tx_data_vld, tx_data_out, fifo_count, fifo_empty, overflow
  );

  modport slave (
    input  wr_en, wr_data, flush, ovf_clr, tx_active,
    output wr_ready, tx_data_vld, tx_data_out, fifo_count, fifo_empty, overflow
  );

endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// rtl/uart_tx_fifo_sync_fifo.sv - single-clock FIFO with occupancy count and flush
module sync_fifo #(
  parameter int width = 8,
  parameter int depth = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [width-1:0]           wdata,
  output logic [width-1:0]           rdata,
  output logic [$clog2(depth):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(depth);
  localparam int CW = PW + 1;

  logic [width-1:0] mem [depth];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             push_ok;
  logic             pop_ok;

  // Flush discards a same-cycle push; full is judged on the registered count only.
  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (flush) begin
        rd_ptr  <= wr_ptr;
        count_q <= '0;
      end else begin
        if (pop_ok) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
      end
    end
  end

  assign rdata = mem[rd_ptr];
  assign count = count_q;
  assign full  = (count_q == CW'(depth));
  assign empty = (count_q == '0);

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - transmit FIFO that paces bytes into uart_tx as one-cycle start pulses
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int data_bits  = DATA_BITS_DEF,
  parameter int fifo_depth = FIFO_DEPTH_DEF
) (
  input logic           clk,
  input logic           rst,
  uart_tx_fifo_if.slave bus
);

  localparam int CW = $clog2(fifo_depth) + 1;

  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [data_bits-1:0] head;
  logic [CW-1:0]        count;

  tx_state_t            state_q;
  tx_state_t            state_d;
  logic [1:0]           timer_q;
  logic                 vld_q;
  logic [data_bits-1:0] data_q;
  logic                 ovf_q;

  assign push = bus.wr_en & ~full;

  sync_fifo #(
    .width (data_bits),
    .depth (fifo_depth)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.flush),
    .wdata (bus.wr_data),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= (state_q == S_WAIT_BUSY) ? timer_q + 1'b1 : 2'd0;
    end
  end

  // WAIT_BUSY gives up if uart_tx never raises tx_active, so a mismatched uart cannot stall the queue.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (pop) state_d = S_ISSUE;
      S_ISSUE:     state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (bus.tx_active) begin
          state_d = S_WAIT_DONE;
        end else if (timer_q == 2'(WAIT_BUSY_TIMEOUT - 1)) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_DONE: if (!bus.tx_active) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pop = 1'b0;
    if (state_q == S_IDLE && !empty && !bus.tx_active && !bus.flush) begin
      pop = 1'b1;
    end
  end

  // A write attempt while full sets overflow even when ovf_clr is asserted in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      vld_q <= pop;
      if (pop) begin
        data_q <= head;
      end
      if (bus.wr_en && full) begin
        ovf_q <= 1'b1;
      end else if (bus.ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign bus.wr_ready    = ~full;
  assign bus.tx_data_vld = vld_q;
  assign bus.tx_data_out = data_q;
  assign bus.fifo_count  = count;
  assign bus.fifo_empty  = empty;
  assign bus.overflow    = ovf_q;

endmodule
